// File: rtl/ysyx_22040632_dcache_pkg.sv
// Shared types for the D-cache tag/state array: per-line state record,
// flush-walker state encoding and a small line-state helper.
package ysyx_22040632_dcache_pkg;

  // Stored tag width of a line record; the tag array top defaults to this.
  localparam int LINE_TAG_W = 21;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [LINE_TAG_W-1:0] tag;
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    WB    = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } flush_state_e;

  localparam line_state_t LINE_RESET = '{valid: 1'b0, dirty: 1'b0, tag: {LINE_TAG_W{1'b0}}};

  // A line needs write-back only when it holds live, modified data.
  function automatic logic line_needs_wb(input line_state_t line);
    return line.valid & line.dirty;
  endfunction

endpackage

// File: rtl/ysyx_22040632_plru_tree.sv
// Tree pseudo-LRU for one set. Node bits are heap-ordered (node 0 = root,
// children of n at 2n+1 / 2n+2). A node bit of 0 points the victim search
// left, 1 points it right; touching a way flips every node on its path to
// point away from it.
module ysyx_22040632_plru_tree
  import ysyx_22040632_dcache_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits_i,
  input  logic [WAY_W-1:0] mru_way_i,
  output logic [WAY_W-1:0] victim_way_o,
  output logic [WAYS-2:0]  next_bits_o
);

  // Follow the node bits from the root down to the pseudo-least-recent way.
  always_comb begin
    logic [WAY_W:0] node;
    node         = {(WAY_W+1){1'b0}};
    victim_way_o = {WAY_W{1'b0}};
    for (int l = 0; l < WAY_W; l++) begin
      victim_way_o[WAY_W-1-l] = bits_i[node[WAY_W-1:0]];
      node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, bits_i[node[WAY_W-1:0]]};
    end
  end

  // Point every node on the MRU way's path at the opposite subtree.
  always_comb begin
    logic [WAY_W:0] node;
    node        = {(WAY_W+1){1'b0}};
    next_bits_o = bits_i;
    for (int l = 0; l < WAY_W; l++) begin
      next_bits_o[node[WAY_W-1:0]] = ~mru_way_i[WAY_W-1-l];
      node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, mru_way_i[WAY_W-1-l]};
    end
  end

endmodule

// File: rtl/ysyx_22040632_dtag_nway.sv
// N-way set-associative D-cache tag/state array with tree-PLRU replacement
// and a flush walker that offers every dirty line for write-back and then
// invalidates the whole array.
// Optional build macro DTAG_PERF_EN adds saturating hit/miss counters
// (perf_hit / perf_miss ports).
module ysyx_22040632_dtag_nway
  import ysyx_22040632_dcache_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 32,
  parameter  int TAG_W = LINE_TAG_W,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rrst_n,
  input  logic             lk_valid,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic [IDX_W-1:0] lk_index,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag,
  input  logic             fill_en,
  input  logic [WAY_W-1:0] fill_way,
  input  logic             fill_dirty,
  input  logic             mark_dirty,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_index,
  output logic [WAY_W-1:0] wb_way,
  output logic [TAG_W-1:0] wb_tag,
  output logic             flush_done
`ifdef DTAG_PERF_EN
  ,
  output logic [31:0]      perf_hit,
  output logic [31:0]      perf_miss
`endif
);

  localparam int                LINES     = SETS * WAYS;
  localparam int                SCAN_W    = IDX_W + WAY_W;
  localparam logic [SCAN_W-1:0] SCAN_LAST = {SCAN_W{1'b1}};
  localparam logic [SCAN_W-1:0] SCAN_ONE  = {{(SCAN_W-1){1'b0}}, 1'b1};

  // Line storage is addressed as {set, way}, so the scan counter doubles as
  // a set-major line address.
  line_state_t       lines_q [LINES];
  line_state_t       lines_d [LINES];
  logic [WAYS-2:0]   plru_q  [SETS];
  logic [WAYS-2:0]   plru_d  [SETS];
  flush_state_e      state_q, state_d;
  logic [SCAN_W-1:0] scan_q,  scan_d;

  logic [WAYS-1:0]   match_s;
  logic [WAYS-1:0]   invalid_s;
  logic              any_match_s;
  logic              busy_s;
  logic              hit_s;
  logic [WAY_W-1:0]  match_way_s;
  logic [WAY_W-1:0]  inv_way_s;
  logic [WAY_W-1:0]  plru_victim_s;
  logic [WAY_W-1:0]  victim_way_s;
  logic [WAY_W-1:0]  mru_way_s;
  logic [WAYS-2:0]   plru_next_s;
  line_state_t       victim_line_s;
  line_state_t       scan_line_s;

  // Tag compare and invalid-way detection across the addressed set.
  always_comb begin
    match_s   = {WAYS{1'b0}};
    invalid_s = {WAYS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      match_s[w]   = lines_q[{lk_index, WAY_W'(w)}].valid &&
                     (lines_q[{lk_index, WAY_W'(w)}].tag == LINE_TAG_W'(lk_tag));
      invalid_s[w] = ~lines_q[{lk_index, WAY_W'(w)}].valid;
    end
  end

  // Lowest-numbered matching way and lowest-numbered invalid way.
  always_comb begin
    match_way_s = {WAY_W{1'b0}};
    inv_way_s   = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_way_s = match_s[w]   ? WAY_W'(w) : match_way_s;
      inv_way_s   = invalid_s[w] ? WAY_W'(w) : inv_way_s;
    end
  end

  assign busy_s      = (state_q != IDLE);
  assign any_match_s = |match_s;
  assign hit_s       = any_match_s & ~busy_s;
  assign mru_way_s   = fill_en ? fill_way : match_way_s;

  ysyx_22040632_plru_tree #(
    .WAYS (WAYS)
  ) u_plru (
    .bits_i       (plru_q[lk_index]),
    .mru_way_i    (mru_way_s),
    .victim_way_o (plru_victim_s),
    .next_bits_o  (plru_next_s)
  );

  assign victim_way_s  = (|invalid_s) ? inv_way_s : plru_victim_s;
  assign victim_line_s = lines_q[{lk_index, victim_way_s}];
  assign scan_line_s   = lines_q[scan_q];

  assign hit          = hit_s;
  assign hit_way      = hit_s ? match_way_s : {WAY_W{1'b0}};
  assign victim_way   = victim_way_s;
  assign victim_dirty = line_needs_wb(victim_line_s);
  assign victim_tag   = TAG_W'(victim_line_s.tag);

  // Walker-visible outputs decode straight from registered state.
  assign flush_busy = busy_s;
  assign wb_valid   = (state_q == WB);
  assign flush_done = (state_q == DONE);
  assign wb_index   = scan_q[SCAN_W-1:WAY_W];
  assign wb_way     = scan_q[WAY_W-1:0];
  assign wb_tag     = TAG_W'(scan_line_s.tag);

  // Next array/PLRU/walker state: normal access in IDLE, flush walk otherwise.
  always_comb begin
    lines_d = lines_q;
    plru_d  = plru_q;
    state_d = state_q;
    scan_d  = scan_q;
    case (state_q)
      IDLE: begin
        if (fill_en) begin
          lines_d[{lk_index, fill_way}] = '{valid: 1'b1, dirty: fill_dirty,
                                            tag: LINE_TAG_W'(lk_tag)};
        end else if (mark_dirty && hit_s) begin
          lines_d[{lk_index, match_way_s}].dirty = 1'b1;
        end else begin
          lines_d = lines_q;
        end
        if (fill_en || (lk_valid && hit_s)) begin
          plru_d[lk_index] = plru_next_s;
        end else begin
          plru_d = plru_q;
        end
        if (flush_req) begin
          state_d = SCAN;
          scan_d  = {SCAN_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (line_needs_wb(scan_line_s)) begin
          state_d = WB;
        end else if (scan_q == SCAN_LAST) begin
          state_d = CLEAR;
          scan_d  = {SCAN_W{1'b0}};
        end else begin
          scan_d = scan_q + SCAN_ONE;
        end
      end
      WB: begin
        // Counter holds here, so the offered fields stay stable; the line is
        // re-scanned once clean and the walk then moves on.
        if (wb_ready) begin
          lines_d[scan_q].dirty = 1'b0;
          state_d = SCAN;
        end else begin
          state_d = WB;
        end
      end
      CLEAR: begin
        for (int i = 0; i < LINES; i++) begin
          lines_d[i].valid = 1'b0;
          lines_d[i].dirty = 1'b0;
        end
        for (int s = 0; s < SETS; s++) begin
          plru_d[s] = {(WAYS-1){1'b0}};
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        scan_d  = {SCAN_W{1'b0}};
      end
      default: begin
        state_d = IDLE;
        scan_d  = {SCAN_W{1'b0}};
      end
    endcase
  end

  // Array, PLRU and walker registers; reset aborts any walk and clears state.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      scan_q  <= {SCAN_W{1'b0}};
      for (int i = 0; i < LINES; i++) begin
        lines_q[i] <= LINE_RESET;
      end
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= {(WAYS-1){1'b0}};
      end
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      lines_q <= lines_d;
      plru_q  <= plru_d;
    end
  end

`ifdef DTAG_PERF_EN
  logic [31:0] perf_hit_q,  perf_hit_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  // Saturating lookup hit/miss counters, frozen while the walker runs.
  always_comb begin
    perf_hit_d  = perf_hit_q;
    perf_miss_d = perf_miss_q;
    if (lk_valid && !busy_s && any_match_s && (perf_hit_q != 32'hFFFF_FFFF)) begin
      perf_hit_d = perf_hit_q + 32'd1;
    end else begin
      perf_hit_d = perf_hit_q;
    end
    if (lk_valid && !busy_s && !any_match_s && (perf_miss_q != 32'hFFFF_FFFF)) begin
      perf_miss_d = perf_miss_q + 32'd1;
    end else begin
      perf_miss_d = perf_miss_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_ysyx_22040632_dtag_nway.sv
// Self-checking bench for the D-cache tag/state array: lookup, PLRU victim,
// dirty marking, flush walk with back-pressure, busy gating and reset abort.
module tb_ysyx_22040632_dtag_nway;

  localparam int WAYS  = 4;
  localparam int SETS  = 32;
  localparam int TAG_W = 21;
  localparam int IDX_W = 5;
  localparam int WAY_W = 2;

  logic             clk = 1'b0;
  logic             rrst_n;
  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] lk_index;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             victim_dirty;
  logic [TAG_W-1:0] victim_tag;
  logic             fill_en;
  logic [WAY_W-1:0] fill_way;
  logic             fill_dirty;
  logic             mark_dirty;
  logic             flush_req;
  logic             flush_busy;
  logic             wb_valid;
  logic             wb_ready;
  logic [IDX_W-1:0] wb_index;
  logic [WAY_W-1:0] wb_way;
  logic [TAG_W-1:0] wb_tag;
  logic             flush_done;

  always #5 clk = ~clk;

  ysyx_22040632_dtag_nway dut (
    .clk          (clk),
    .rrst_n       (rrst_n),
    .lk_valid     (lk_valid),
    .lk_tag       (lk_tag),
    .lk_index     (lk_index),
    .hit          (hit),
    .hit_way      (hit_way),
    .victim_way   (victim_way),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .fill_en      (fill_en),
    .fill_way     (fill_way),
    .fill_dirty   (fill_dirty),
    .mark_dirty   (mark_dirty),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_index     (wb_index),
    .wb_way       (wb_way),
    .wb_tag       (wb_tag),
    .flush_done   (flush_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected write-back beats, pushed when dirty lines are created.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way;
    logic [TAG_W-1:0] tag;
  } wb_exp_t;
  wb_exp_t wb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    lk_valid   = 1'b0;
    lk_tag     = '0;
    lk_index   = '0;
    fill_en    = 1'b0;
    fill_way   = '0;
    fill_dirty = 1'b0;
    mark_dirty = 1'b0;
    flush_req  = 1'b0;
    wb_ready   = 1'b0;
  endtask

  task automatic do_fill(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way,
                         input logic [TAG_W-1:0] tag, input logic dirty);
    @(negedge clk);
    lk_valid   = 1'b0;
    mark_dirty = 1'b0;
    lk_index   = idx;
    lk_tag     = tag;
    fill_way   = way;
    fill_dirty = dirty;
    fill_en    = 1'b1;
    @(negedge clk);
    fill_en    = 1'b0;
    fill_dirty = 1'b0;
  endtask

  // Present a lookup for exactly one posedge; outputs settle by return.
  task automatic look(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                      input logic v, input logic md);
    @(negedge clk);
    lk_index   = idx;
    lk_tag     = tag;
    lk_valid   = v;
    mark_dirty = md;
    #1;
  endtask

  initial begin
    int beats;
    int stall;
    int done_cnt;
    int tries;
    int busy_cnt;
    bit found;
    wb_exp_t exp_beat;

    idle_inputs();
    rrst_n = 1'b0;
    repeat (2) @(negedge clk);
    rrst_n = 1'b1;

    // 1: reset state and an empty-array lookup
    look(5'd3, 21'h1, 1'b0, 1'b0);
    check_eq("rst_hit", 32'(hit), 32'd0);
    check_eq("rst_victim_way", 32'(victim_way), 32'd0);
    check_eq("rst_victim_dirty", 32'(victim_dirty), 32'd0);
    check_eq("rst_busy", 32'(flush_busy), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_flush_done", 32'(flush_done), 32'd0);

    // 2: fill a full set, PLRU victim before and after a hit
    for (int w = 0; w < WAYS; w++) begin
      do_fill(5'd5, WAY_W'(w), 21'hA + 21'(w), 1'b0);
    end
    look(5'd5, 21'hB, 1'b0, 1'b0);
    check_eq("set5_hit", 32'(hit), 32'd1);
    check_eq("set5_hit_way", 32'(hit_way), 32'd1);
    check_eq("set5_victim_pre", 32'(victim_way), 32'd0);
    look(5'd5, 21'hB, 1'b1, 1'b0);
    look(5'd5, 21'h99, 1'b0, 1'b1);
    check_eq("set5_miss", 32'(hit), 32'd0);
    check_eq("set5_miss_way", 32'(hit_way), 32'd0);
    check_eq("set5_victim_post", 32'(victim_way), 32'd2);
    check_eq("set5_victim_tag", 32'(victim_tag), 32'hC);
    check_eq("set5_victim_dirty", 32'(victim_dirty), 32'd0);

    // 3: store hit marks a clean line dirty; steer PLRU onto it
    do_fill(5'd7, 2'd0, 21'h50, 1'b0);
    do_fill(5'd7, 2'd1, 21'h51, 1'b0);
    do_fill(5'd7, 2'd3, 21'h53, 1'b0);
    do_fill(5'd7, 2'd2, 21'h55, 1'b0);
    look(5'd7, 21'h55, 1'b1, 1'b1);
    check_eq("set7_hit_way2", 32'(hit_way), 32'd2);
    look(5'd7, 21'h53, 1'b1, 1'b0);
    check_eq("set7_hit_way3", 32'(hit_way), 32'd3);
    look(5'd7, 21'h50, 1'b1, 1'b0);
    check_eq("set7_hit_way0", 32'(hit_way), 32'd0);
    look(5'd7, 21'h1FF, 1'b0, 1'b0);
    check_eq("set7_victim_way", 32'(victim_way), 32'd2);
    check_eq("set7_victim_dirty", 32'(victim_dirty), 32'd1);
    check_eq("set7_victim_tag", 32'(victim_tag), 32'h55);

    // 4/5: flush with back-pressure, ignored fill/lookup/flush_req while busy
    do_fill(5'd2, 2'd1, 21'h22, 1'b1);
    do_fill(5'd30, 2'd3, 21'h3E, 1'b1);
    wb_q.push_back('{idx: 5'd2,  way: 2'd1, tag: 21'h22});
    wb_q.push_back('{idx: 5'd7,  way: 2'd2, tag: 21'h55});
    wb_q.push_back('{idx: 5'd30, way: 2'd3, tag: 21'h3E});
    idle_inputs();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    check_eq("flush_busy_start", 32'(flush_busy), 32'd1);
    beats = 0; stall = 0; done_cnt = 0; tries = 0;
    while (done_cnt == 0 && tries < 1000) begin
      @(negedge clk);
      tries++;
      fill_en   = 1'b0;
      flush_req = 1'b0;
      lk_valid  = 1'b0;
      if (tries == 3) begin
        lk_index = 5'd31; lk_tag = 21'h77; fill_way = 2'd0; fill_dirty = 1'b1; fill_en = 1'b1;
      end
      if (tries == 4) begin
        lk_index = 5'd5; lk_tag = 21'hA; lk_valid = 1'b1; fill_dirty = 1'b0;
        #1;
        check_eq("busy_hit_gated", 32'(hit), 32'd0);
      end
      if (tries == 40) flush_req = 1'b1;
      if (flush_done) done_cnt++;
      if (wb_valid) begin
        if (wb_q.size() > 0) begin
          exp_beat = wb_q[0];
          check_eq("wb_fields", 32'({wb_index, wb_way, wb_tag}), 32'(exp_beat));
        end
        if (beats == 0 && stall < 5) begin
          stall++;
          wb_ready = 1'b0;
        end else begin
          wb_ready = 1'b1;
          if (wb_q.size() > 0) void'(wb_q.pop_front());
          beats++;
        end
      end else begin
        wb_ready = 1'b0;
      end
    end
    check_eq("flush_done_seen", 32'(done_cnt), 32'd1);
    check_eq("wb_beat_count", 32'(beats), 32'd3);
    check_eq("wb_queue_left", 32'(wb_q.size()), 32'd0);
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("post_flush_done", 32'(flush_done), 32'd0);
      check_eq("post_flush_busy", 32'(flush_busy), 32'd0);
    end
    look(5'd5, 21'hA, 1'b0, 1'b0);
    check_eq("post_miss_5", 32'(hit), 32'd0);
    check_eq("post_victim_5", 32'(victim_way), 32'd0);
    look(5'd2, 21'h22, 1'b0, 1'b0);
    check_eq("post_miss_2", 32'(hit), 32'd0);
    look(5'd7, 21'h55, 1'b0, 1'b0);
    check_eq("post_miss_7", 32'(hit), 32'd0);
    look(5'd30, 21'h3E, 1'b0, 1'b0);
    check_eq("post_miss_30", 32'(hit), 32'd0);
    look(5'd31, 21'h77, 1'b0, 1'b0);
    check_eq("post_miss_31", 32'(hit), 32'd0);

    // Clean-array walk length
    idle_inputs();
    @(negedge clk);
    flush_req = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (flush_busy) busy_cnt++;
      else break;
    end
    check_eq("clean_walk_cycles", 32'(busy_cnt), 32'(SETS * WAYS + 2));

    // 6: reset asserted while a line is offered for write-back
    do_fill(5'd4, 2'd0, 21'h44, 1'b1);
    idle_inputs();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (wb_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("rst_wb_seen", 32'(found), 32'd1);
    check_eq("rst_wb_index", 32'(wb_index), 32'd4);
    rrst_n = 1'b0;
    #1;
    check_eq("abort_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("abort_busy", 32'(flush_busy), 32'd0);
    check_eq("abort_done", 32'(flush_done), 32'd0);
    @(negedge clk);
    rrst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (flush_done) done_cnt++;
    end
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    look(5'd4, 21'h44, 1'b0, 1'b0);
    check_eq("abort_miss", 32'(hit), 32'd0);
    check_eq("abort_victim_dirty", 32'(victim_dirty), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
